data_sram_resp: RTL

//   Responder side of the data SRAM port driven by the MEM stage. Serves CPU loads/stores

---
 rtl/data_sram_resp_pkg.sv | 24 ++
 rtl/data_sram_resp_if.sv | 26 ++
 rtl/data_sram_resp_print_fifo.sv | 57 +++++
 rtl/data_sram_resp.sv | 126 ++++++++++++
 4 files changed

// File: rtl/data_sram_resp_pkg.sv
// Shared definitions for the data SRAM responder: MMIO map, status bits, request payload.
package data_sram_resp_pkg;

    localparam logic [31:0] MMIO_BASE_DEFAULT = 32'hBFAF_0000;

    typedef enum logic [1:0] {
        REG_TIMER   = 2'd0,
        REG_SCRATCH = 2'd1,
        REG_PRINT   = 2'd2,
        REG_RSVD    = 2'd3
    } mmio_reg_e;

    localparam int unsigned STAT_EMPTY_BIT = 1;
    localparam int unsigned STAT_FULL_BIT  = 2;
    localparam int unsigned STAT_OVF_BIT   = 3;

    typedef struct packed {
        logic        en;
        logic [3:0]  we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } data_sram_req_t;

endpackage

// File: rtl/data_sram_resp_if.sv
// Data SRAM port between the MEM stage (master) and the responder (slave).
interface data_sram_resp_if;

    logic        data_sram_en;
    logic [3:0]  data_sram_we;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic [31:0] data_sram_rdata;

    modport master (
        output data_sram_en,
        output data_sram_we,
        output data_sram_addr,
        output data_sram_wdata,
        input  data_sram_rdata
    );

    modport slave (
        input  data_sram_en,
        input  data_sram_we,
        input  data_sram_addr,
        input  data_sram_wdata,
        output data_sram_rdata
    );

endinterface

// File: rtl/data_sram_resp_print_fifo.sv
// Synchronous character FIFO with sticky overflow; a push into a full FIFO survives only if a pop frees a slot.
module data_sram_resp_print_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned DW    = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic [DW-1:0] head,
    output logic          full,
    output logic          empty,
    output logic          overflow
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          do_push_c;
    logic          do_pop_c;

    assign empty     = (count == '0);
    assign full      = (count == CW'(DEPTH));
    assign head      = mem[rd_ptr];
    assign do_pop_c  = pop & ~empty;
    assign do_push_c = push & (~full | do_pop_c);

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push_c) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop_c) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(do_push_c) - CW'(do_pop_c);
            if (push & ~do_push_c) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/data_sram_resp.sv
// Data SRAM responder: byte-strobed word RAM with 1-cycle read latency plus an MMIO
// window holding a free-running timer, a scratch register and a print FIFO.
module data_sram_resp
    import data_sram_resp_pkg::*;
#(
    parameter int unsigned RAM_AW      = 14,
    parameter logic [31:0] MMIO_BASE   = MMIO_BASE_DEFAULT,
    parameter int unsigned PRINT_DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    data_sram_resp_if.slave        bus,
    output logic                   print_valid,
    output logic [7:0]             print_data,
    input  logic                   print_ready
);

    localparam int unsigned DEPTH = 2 ** RAM_AW;

    data_sram_req_t    req;
    logic              is_mmio_c;
    mmio_reg_e         sel_c;
    logic [RAM_AW-1:0] ram_idx_c;
    logic              wr_c;
    logic              rd_c;
    logic              ram_wr_c;
    logic              scratch_wr_c;
    logic              push_c;
    logic [31:0]       mmio_rdata_c;
    logic [31:0]       status_c;
    logic [31:0]       mem [DEPTH];
    logic [31:0]       rdata;
    logic [31:0]       timer;
    logic [31:0]       scratch;
    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_overflow;
    logic              unused_addr;

    assign req = '{en:    bus.data_sram_en,
                   we:    bus.data_sram_we,
                   addr:  bus.data_sram_addr,
                   wdata: bus.data_sram_wdata};

    assign is_mmio_c    = (req.addr[31:16] == MMIO_BASE[31:16]);
    assign sel_c        = mmio_reg_e'(req.addr[3:2]);
    assign ram_idx_c    = req.addr[RAM_AW+1:2];
    assign wr_c         = req.en & (|req.we);
    assign rd_c         = req.en & ~(|req.we);
    assign ram_wr_c     = wr_c & ~is_mmio_c;
    assign scratch_wr_c = wr_c & is_mmio_c & (sel_c == REG_SCRATCH);
    assign push_c       = wr_c & is_mmio_c & (sel_c == REG_PRINT) & req.we[0];
    assign unused_addr  = ^req.addr;

    assign bus.data_sram_rdata = rdata;
    assign print_valid         = ~fifo_empty;

    // Status word: {28'b0, overflow, full, empty, 1'b0}
    always_comb begin
        status_c                 = '0;
        status_c[STAT_EMPTY_BIT] = fifo_empty;
        status_c[STAT_FULL_BIT]  = fifo_full;
        status_c[STAT_OVF_BIT]   = fifo_overflow;
    end

    always_comb begin
        mmio_rdata_c = '0;
        case (sel_c)
            REG_TIMER:   mmio_rdata_c = timer;
            REG_SCRATCH: mmio_rdata_c = scratch;
            REG_PRINT:   mmio_rdata_c = status_c;
            default:     mmio_rdata_c = '0;
        endcase
    end

    // RAM array is not reset so it maps onto a plain SRAM macro
    always_ff @(posedge clk) begin
        if (ram_wr_c) begin
            for (int i = 0; i < 4; i++) begin
                if (req.we[i]) begin
                    mem[ram_idx_c][8*i +: 8] <= req.wdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rdata <= '0;
        end else if (rd_c) begin
            rdata <= is_mmio_c ? mmio_rdata_c : mem[ram_idx_c];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            timer   <= '0;
            scratch <= '0;
        end else begin
            timer <= timer + 32'd1;
            if (scratch_wr_c) begin
                for (int i = 0; i < 4; i++) begin
                    if (req.we[i]) begin
                        scratch[8*i +: 8] <= req.wdata[8*i +: 8];
                    end
                end
            end
        end
    end

    data_sram_resp_print_fifo #(
        .DEPTH (PRINT_DEPTH),
        .DW    (8)
    ) u_print_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push_c),
        .push_data (req.wdata[7:0]),
        .pop       (print_ready),
        .head      (print_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .overflow  (fifo_overflow)
    );

endmodule
